// File: rtl/os_lane_collector_pkg.sv
// Shared definitions for the ordered-set lane collector: PIPE symbol
// constants, ordered-set geometry and the per-lane FSM encoding.
package os_lane_collector_pkg;

   localparam int NUM_LANES = 16;
   localparam int OS_W      = 128;
   localparam int OS_SYMS   = OS_W / 8;

   localparam logic [7:0] COM    = 8'hBC;
   localparam logic [7:0] SKP    = 8'h1C;
   localparam logic [7:0] TS1_ID = 8'h1E;
   localparam logic [7:0] TS2_ID = 8'h2D;

   // Sync header value that marks an ordered-set block at Gen3+
   localparam logic [1:0] SYNC_OS = 2'b01;

   typedef enum logic [1:0] {
      LANE_IDLE    = 2'd0,
      LANE_COLLECT = 2'd1,
      LANE_HOLD    = 2'd2
   } lane_state_t;

   function automatic logic is_ts_id(input logic [7:0] sym);
      return (sym == TS1_ID) || (sym == TS2_ID);
   endfunction

endpackage

// File: rtl/os_lane_assembler.sv
// One lane of the ordered-set collector: finds the start of a training set,
// packs received symbols into a 128-bit buffer and holds the completed set
// until the top releases or flushes all lanes.
// Build option OSC_SKP_FILTER_EN: drop K-coded SKP symbols inside a Gen1/2
// set instead of aborting it.
module os_lane_assembler
   import os_lane_collector_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic [2:0]      sym_count,
   input  logic            hi_rate,
   input  logic [31:0]     data,
   input  logic [3:0]      data_k,
   input  logic            valid,
   input  logic            start_block,
   input  logic [1:0]      sync_header,
   input  logic            release_req,
   input  logic            flush,
   output logic            in_hold,
   output logic [OS_W-1:0] os_buf
);

`ifdef OSC_SKP_FILTER_EN
   localparam bit SKP_FILTER = 1'b1;
`else
   localparam bit SKP_FILTER = 1'b0;
`endif

   lane_state_t     state, state_next;
   logic [4:0]      cnt, cnt_next;
   logic [OS_W-1:0] buf_next;
   logic            started;
   logic            stop;

   // State, symbol count and packed buffer registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= LANE_IDLE;
         cnt    <= '0;
         os_buf <= '0;
      end else begin
         state  <= state_next;
         cnt    <= cnt_next;
         os_buf <= buf_next;
      end
   end

   // Next state: start detection, byte packing and abort conditions
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      buf_next   = os_buf;
      started    = 1'b0;
      stop       = 1'b0;
      if (release_req || flush) begin
         state_next = LANE_IDLE;
         cnt_next   = '0;
      end else begin
         case (state)
            LANE_IDLE: begin
               if (valid) begin
                  // Gen3+ sets are always aligned to byte 0 of the block start
                  if (hi_rate)
                     started = start_block && (sync_header == SYNC_OS) && is_ts_id(data[7:0]);
                  for (int j = 0; j < 4; j++) begin
                     if (j < int'(sym_count)) begin
                        if (!hi_rate && !started && data_k[j] && (data[8*j +: 8] == COM))
                           started = 1'b1;
                        if (started && (cnt_next < 5'd16)) begin
                           buf_next[{cnt_next[3:0], 3'b000} +: 8] = data[8*j +: 8];
                           cnt_next = cnt_next + 5'd1;
                        end
                     end
                  end
                  if (started)
                     state_next = (cnt_next == 5'd16) ? LANE_HOLD : LANE_COLLECT;
               end
            end
            LANE_COLLECT: begin
               if (!valid || (hi_rate && start_block && (sync_header != SYNC_OS))) begin
                  stop = 1'b1;
               end else begin
                  // Bytes beyond the 16th symbol of this word are discarded
                  for (int j = 0; j < 4; j++) begin
                     if ((j < int'(sym_count)) && !stop && (cnt_next < 5'd16)) begin
                        if (!hi_rate && data_k[j] && (data[8*j +: 8] == COM)) begin
                           stop = 1'b1;
                        end else if (!hi_rate && data_k[j] && (data[8*j +: 8] == SKP)) begin
                           stop = !SKP_FILTER;
                        end else begin
                           buf_next[{cnt_next[3:0], 3'b000} +: 8] = data[8*j +: 8];
                           cnt_next = cnt_next + 5'd1;
                        end
                     end
                  end
               end
               if (stop) begin
                  state_next = LANE_IDLE;
                  cnt_next   = '0;
               end else if (cnt_next == 5'd16) begin
                  state_next = LANE_HOLD;
               end
            end
            LANE_HOLD: begin
               state_next = LANE_HOLD;
            end
            default: begin
               state_next = LANE_IDLE;
               cnt_next   = '0;
            end
         endcase
      end
   end

   // Lane status seen by the top-level all-hold detector
   always_comb begin
      in_hold = (state == LANE_HOLD);
   end

endmodule

// File: rtl/os_lane_collector.sv
// Ordered-set lane collector: assembles 16-symbol training sets on every
// PIPE lane, deskews completed sets across the detected lanes and presents
// them as one 2048-bit word with a single-cycle valid.
// Build option OSC_SKP_FILTER_EN is passed through to the lane assemblers.
module os_lane_collector
   import os_lane_collector_pkg::*;
#(
   parameter int GEN1_PIPEWIDTH = 8,
   parameter int GEN2_PIPEWIDTH = 8,
   parameter int GEN3_PIPEWIDTH = 8,
   parameter int GEN4_PIPEWIDTH = 8,
   parameter int GEN5_PIPEWIDTH = 8,
   parameter int DESKEW_LIMIT   = 20
)
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic [2:0]                gen,
   input  logic [4:0]                numberOfDetectedLanes,
   input  logic [511:0]              rxData,
   input  logic [63:0]               rxDataK,
   input  logic [15:0]               rxValid,
   input  logic [15:0]               rxStartBlock,
   input  logic [31:0]               rxSyncHeader,
   output logic [NUM_LANES*OS_W-1:0] orderedSets,
   output logic                      validOrderedSets,
   output logic [7:0]                deskewErrors
);

   localparam int              TW       = $clog2(DESKEW_LIMIT + 1);
   localparam logic [TW-1:0]   LIMIT_M1 = TW'(DESKEW_LIMIT - 1);

   function automatic logic [2:0] width_syms(input int w);
      return 3'(w / 8);
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   logic [2:0]                 sym_count;
   logic                       hi_rate;
   logic [4:0]                 n_eff;
   logic [NUM_LANES-1:0]       active;
   logic [NUM_LANES-1:0]       hold;
   logic [OS_W-1:0]            lane_buf [NUM_LANES];
   logic [NUM_LANES*OS_W-1:0]  os_masked;
   logic [2:0]                 gen_q;
   logic [4:0]                 n_q;
   logic [TW-1:0]              timer;
   logic                       all_hold;
   logic                       partial;
   logic                       timeout;
   logic                       flush_all;
   logic                       release_all;

   // Symbols per cycle for the current rate, lane-count clamp and active mask
   always_comb begin
      case (gen)
         3'd2:    sym_count = width_syms(GEN2_PIPEWIDTH);
         3'd3:    sym_count = width_syms(GEN3_PIPEWIDTH);
         3'd4:    sym_count = width_syms(GEN4_PIPEWIDTH);
         3'd5:    sym_count = width_syms(GEN5_PIPEWIDTH);
         default: sym_count = width_syms(GEN1_PIPEWIDTH);
      endcase
      hi_rate = (gen >= 3'd3);
      if (numberOfDetectedLanes == 5'd0)
         n_eff = 5'd1;
      else if (numberOfDetectedLanes > 5'd16)
         n_eff = 5'd16;
      else
         n_eff = numberOfDetectedLanes;
      for (int i = 0; i < NUM_LANES; i++)
         active[i] = (i < int'(n_eff));
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      os_lane_assembler u_lane (
         .clk         (clk),
         .reset       (reset),
         .sym_count   (sym_count),
         .hi_rate     (hi_rate),
         .data        (rxData[32*i +: 32]),
         .data_k      (rxDataK[4*i +: 4]),
         .valid       (rxValid[i]),
         .start_block (rxStartBlock[i]),
         .sync_header (rxSyncHeader[2*i +: 2]),
         .release_req (release_all),
         .flush       (flush_all),
         .in_hold     (hold[i]),
         .os_buf      (lane_buf[i])
      );
   end

   // Hold detection, deskew timeout and lane release/flush decisions.
   // An N change flushes unconditionally; on idle lanes that is a no-op.
   always_comb begin
      all_hold    = &(hold | ~active);
      partial     = (|(hold & active)) && !all_hold;
      timeout     = partial && (timer == LIMIT_M1);
      flush_all   = (gen != gen_q) || (n_eff != n_q) || timeout;
      release_all = all_hold && !flush_all;
      os_masked   = '0;
      for (int i = 0; i < NUM_LANES; i++)
         if (active[i])
            os_masked[OS_W*i +: OS_W] = lane_buf[i];
   end

   // Configuration history used to detect rate and lane-count changes
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gen_q <= 3'd1;
         n_q   <= 5'd1;
      end else begin
         gen_q <= gen;
         n_q   <= n_eff;
      end
   end

   // Deskew timer runs only while some but not all active lanes are holding
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         timer <= '0;
      else if (!partial || flush_all)
         timer <= '0;
      else
         timer <= timer + 1'b1;
   end

   // Output word, single-cycle valid and saturating deskew error count
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         orderedSets      <= '0;
         validOrderedSets <= 1'b0;
         deskewErrors     <= '0;
      end else begin
         validOrderedSets <= release_all;
         if (release_all)
            orderedSets <= os_masked;
         if (timeout)
            deskewErrors <= sat_inc(deskewErrors);
      end
   end

endmodule

// File: tb/tb_os_lane_collector.sv
// Directed bench for os_lane_collector (Gen2 width 32, Gen3 width 16).
module tb_os_lane_collector;

   logic          clk = 1'b0;
   logic          reset;
   logic [2:0]    gen;
   logic [4:0]    numberOfDetectedLanes;
   logic [511:0]  rxData;
   logic [63:0]   rxDataK;
   logic [15:0]   rxValid;
   logic [15:0]   rxStartBlock;
   logic [31:0]   rxSyncHeader;
   logic [2047:0] orderedSets;
   logic          validOrderedSets;
   logic [7:0]    deskewErrors;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [127:0] EXP_G1 = 128'h0F0E0D0C_0B0A0908_07060504_030201BC;
   localparam logic [127:0] EXP_G3 = 128'h0F0E0D0C_0B0A0908_07060504_0302011E;
`ifdef OSC_SKP_FILTER_EN
   localparam bit SKP_DROP = 1'b1;
`else
   localparam bit SKP_DROP = 1'b0;
`endif

   os_lane_collector #(
      .GEN1_PIPEWIDTH (8),
      .GEN2_PIPEWIDTH (32),
      .GEN3_PIPEWIDTH (16),
      .GEN4_PIPEWIDTH (8),
      .GEN5_PIPEWIDTH (8),
      .DESKEW_LIMIT   (20)
   ) dut (
      .clk                   (clk),
      .reset                 (reset),
      .gen                   (gen),
      .numberOfDetectedLanes (numberOfDetectedLanes),
      .rxData                (rxData),
      .rxDataK               (rxDataK),
      .rxValid               (rxValid),
      .rxStartBlock          (rxStartBlock),
      .rxSyncHeader          (rxSyncHeader),
      .orderedSets           (orderedSets),
      .validOrderedSets      (validOrderedSets),
      .deskewErrors          (deskewErrors)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rxData       = '0;
      rxDataK      = '0;
      rxValid      = '0;
      rxStartBlock = '0;
      rxSyncHeader = '0;
   endtask

   task automatic set_cfg(input logic [2:0] g, input logic [4:0] n);
      idle_inputs();
      gen = g;
      numberOfDetectedLanes = n;
      tick();
      tick();
   endtask

   function automatic logic [127:0] slot(input int i);
      return orderedSets[128*i +: 128];
   endfunction

   // One symbol on every lane in mask (8-bit PIPE width)
   task automatic drive_sym(input logic [15:0] mask, input logic [7:0] sym, input logic k);
      idle_inputs();
      for (int i = 0; i < 16; i++) begin
         if (mask[i]) begin
            rxData[32*i +: 8] = sym;
            rxDataK[4*i]      = k;
            rxValid[i]        = 1'b1;
         end
      end
      tick();
   endtask

   // COM then 0x01..0x0F, no valid expected while it is being sent
   task automatic send_g1_set(input logic [15:0] mask, input string tag);
      for (int s = 0; s < 16; s++) begin
         drive_sym(mask, (s == 0) ? 8'hBC : 8'(s), s == 0);
         check({tag, "_early"}, 128'(validOrderedSets), 128'd0);
      end
   endtask

   function automatic logic [7:0] g3sym(input int i);
      return (i == 0) ? 8'h1E : 8'(i);
   endfunction

   task automatic run_g3(input logic [1:0] hdr, input string tag);
      for (int c = 0; c < 8; c++) begin
         idle_inputs();
         rxData[15:0] = {g3sym(2*c+1), g3sym(2*c)};
         rxValid[0]   = 1'b1;
         if (c == 0) begin
            rxStartBlock[0]      = 1'b1;
            rxSyncHeader[1:0]    = hdr;
         end
         tick();
         check({tag, "_early"}, 128'(validOrderedSets), 128'd0);
      end
   endtask

   task automatic test_gen2();
      logic [31:0] g2w [5];
      int lc;
      g2w = '{32'h01BC6655, 32'h05040302, 32'h09080706, 32'h0D0C0B0A, 32'hAAAA0F0E};
      set_cfg(3'd2, 5'd2);
      for (int c = 0; c < 8; c++) begin
         idle_inputs();
         for (int ln = 0; ln < 2; ln++) begin
            lc = c - 3*ln;
            if (lc >= 0 && lc < 5) begin
               rxData[32*ln +: 32] = g2w[lc];
               rxDataK[4*ln +: 4]  = (lc == 0) ? 4'b0100 : 4'b0000;
               rxValid[ln]         = 1'b1;
            end
         end
         tick();
         check("t2_early", 128'(validOrderedSets), 128'd0);
      end
      idle_inputs();
      tick();
      check("t2_valid", 128'(validOrderedSets), 128'd1);
      check("t2_lane0", slot(0), EXP_G1);
      check("t2_lane1", slot(1), EXP_G1);
      check("t2_upper_zero", 128'(|orderedSets[2047:256]), 128'd0);
      check("t2_deskew_err", 128'(deskewErrors), 128'd0);
   endtask

   task automatic test_deskew();
      set_cfg(3'd1, 5'd2);
      send_g1_set(16'h0001, "t4");
      for (int k = 1; k <= 20; k++) begin
         idle_inputs();
         tick();
         check("t4_no_valid", 128'(validOrderedSets), 128'd0);
         if (k == 19) check("t4_err_before", 128'(deskewErrors), 128'd0);
         if (k == 20) check("t4_err_after", 128'(deskewErrors), 128'd1);
      end
      // Both lanes must be back in IDLE: a fresh set releases normally
      send_g1_set(16'h0003, "t4_fresh");
      idle_inputs();
      tick();
      check("t4_fresh_valid", 128'(validOrderedSets), 128'd1);
      check("t4_fresh_lane0", slot(0), EXP_G1);
      check("t4_fresh_lane1", slot(1), EXP_G1);
      check("t4_err_kept", 128'(deskewErrors), 128'd1);
   endtask

   task automatic test_skp();
      logic [7:0] sym;
      logic       k;
      set_cfg(3'd1, 5'd1);
      for (int s = 0; s < 17; s++) begin
         if (s == 0)      begin sym = 8'hBC;      k = 1'b1; end
         else if (s < 6)  begin sym = 8'(s);      k = 1'b0; end
         else if (s == 6) begin sym = 8'h1C;      k = 1'b1; end
         else             begin sym = 8'(s - 1);  k = 1'b0; end
         drive_sym(16'h0001, sym, k);
         check("t5_early", 128'(validOrderedSets), 128'd0);
      end
      idle_inputs();
      tick();
      check("t5_valid", 128'(validOrderedSets), 128'(SKP_DROP));
      check("t5_lane0", slot(0), EXP_G1);
   endtask

   task automatic test_reset();
      for (int s = 0; s < 8; s++)
         drive_sym(16'h0001, (s == 0) ? 8'hBC : 8'(s), s == 0);
      #3;
      reset = 1'b0;
      #1;
      check("t6_os_cleared", 128'(|orderedSets), 128'd0);
      check("t6_valid_cleared", 128'(validOrderedSets), 128'd0);
      check("t6_err_cleared", 128'(deskewErrors), 128'd0);
      for (int c = 0; c < 3; c++)
         drive_sym((c % 2 == 0) ? 16'h0001 : 16'h0000, 8'(8 + c), 1'b0);
      reset = 1'b1;
      idle_inputs();
      tick();
      tick();
      send_g1_set(16'h0001, "t6");
      idle_inputs();
      tick();
      check("t6_valid", 128'(validOrderedSets), 128'd1);
      check("t6_lane0", slot(0), EXP_G1);
      check("t6_err", 128'(deskewErrors), 128'd0);
      tick();
      check("t6_pulse_end", 128'(validOrderedSets), 128'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0;
      gen = 3'd1;
      numberOfDetectedLanes = 5'd4;
      idle_inputs();
      tick();
      tick();
      check("rst_os", 128'(|orderedSets), 128'd0);
      check("rst_valid", 128'(validOrderedSets), 128'd0);
      check("rst_err", 128'(deskewErrors), 128'd0);
      reset = 1'b1;

      // Gen1, width 8, four aligned lanes
      set_cfg(3'd1, 5'd4);
      send_g1_set(16'h000F, "t1");
      idle_inputs();
      tick();
      check("t1_valid", 128'(validOrderedSets), 128'd1);
      check("t1_lane0", slot(0), EXP_G1);
      check("t1_lane3", slot(3), EXP_G1);
      check("t1_upper_zero", 128'(|orderedSets[2047:512]), 128'd0);
      tick();
      check("t1_pulse_end", 128'(validOrderedSets), 128'd0);
      check("t1_hold", slot(0), EXP_G1);

      test_gen2();

      // Gen3, width 16, single lane
      set_cfg(3'd3, 5'd1);
      run_g3(2'b01, "t3");
      idle_inputs();
      tick();
      check("t3_valid", 128'(validOrderedSets), 128'd1);
      check("t3_lane0", slot(0), EXP_G3);
      check("t3_sym0", 128'(orderedSets[7:0]), 128'h1E);
      run_g3(2'b10, "t3_badhdr");
      idle_inputs();
      tick();
      check("t3_badhdr_valid", 128'(validOrderedSets), 128'd0);

      test_deskew();
      test_skp();
      test_reset();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
